// File: rtl/raycast_pkg.sv
// Shared constants, state encoding and row colour helper for the raycaster
// column-rendering stages.
package raycast_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned DIST_W   = 21;
    localparam int unsigned WALL_K   = 7680;

    localparam logic [2:0] CEIL_COLOUR   = 3'b001;
    localparam logic [2:0] FLOOR_COLOUR  = 3'b010;
    localparam logic [2:0] WALL_COLOUR_A = 3'b111;
    localparam logic [2:0] WALL_COLOUR_B = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIVIDE,
        ST_CALC,
        ST_DRAW,
        ST_DONE
    } slice_state_t;

    // Band end is widened so top+h == SCREEN_H cannot wrap.
    function automatic logic [2:0] row_colour(
        input logic [6:0] row,
        input logic [6:0] top,
        input logic [6:0] h,
        input logic       side
    );
        logic [7:0] band_end;
        band_end = {1'b0, top} + {1'b0, h};
        if (row < top)
            return CEIL_COLOUR;
        else if ({1'b0, row} < band_end)
            return side ? WALL_COLOUR_B : WALL_COLOUR_A;
        else
            return FLOOR_COLOUR;
    endfunction

endpackage

// File: rtl/seq_udivider.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, W cycles.
// done is high during the cycle whose closing edge writes the final quotient.
module seq_udivider
    import raycast_pkg::*;
#(
    parameter int unsigned W = DIST_W
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quot_q, quot_d;
    logic [W-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [W:0]    trial;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        // Quotient register doubles as the dividend shift register.
        trial  = {rem_q, quot_q[W-1]};
        if (start) begin
            rem_d  = '0;
            quot_d = dividend;
            div_d  = divisor;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quot_d = {quot_q[W-2:0], 1'b0};
            if (trial >= {1'b0, div_q}) begin
                rem_d     = W'(trial - {1'b0, div_q});
                quot_d[0] = 1'b1;
            end else begin
                rem_d = trial[W-1:0];
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1))
                busy_d = 1'b0;
        end
    end

    assign quotient = quot_q;
    assign done     = busy_q && (cnt_q == CW'(1));

endmodule

// File: rtl/wall_slice_renderer.sv
// Accepts one ray result per column, divides out the projected wall height
// and streams the full ceiling/wall/floor column to the plot interface.
module wall_slice_renderer
    import raycast_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              slice_valid,
    output logic              slice_ready,
    input  logic [7:0]        slice_x,
    input  logic [DIST_W-1:0] slice_dist,
    input  logic              slice_side,
    output logic [7:0]        x,
    output logic [6:0]        y,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              column_done,
    output logic              bad_slice
);

    slice_state_t state_q, state_d;

    logic [7:0] col_q, col_d;
    logic       side_q, side_d;
    logic       full_q, full_d;
    logic [6:0] h_q, h_d;
    logic [6:0] top_q, top_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       done_q, done_d;
    logic       bad_q, bad_d;
    logic       ready_q, ready_d;

    logic              div_start;
    logic              div_done;
    logic [DIST_W-1:0] quot;
    logic [6:0]        h_calc;
    logic [6:0]        top_calc;

    seq_udivider #(
        .W(DIST_W)
    ) u_div (
        .clock    (clock),
        .resetn   (resetn),
        .start    (div_start),
        .dividend (DIST_W'(WALL_K)),
        .divisor  (slice_dist),
        .quotient (quot),
        .done     (div_done)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            side_q   <= 1'b0;
            full_q   <= 1'b0;
            h_q      <= '0;
            top_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
            bad_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            side_q   <= side_d;
            full_q   <= full_d;
            h_q      <= h_d;
            top_q    <= top_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
            bad_q    <= bad_d;
            ready_q  <= ready_d;
        end
    end

    // Non-positive distances bypass the divider and draw a full-height wall.
    always_comb begin
        if (full_q || quot >= DIST_W'(SCREEN_H))
            h_calc = 7'(SCREEN_H);
        else
            h_calc = quot[6:0];
        top_calc = (7'(SCREEN_H) - h_calc) >> 1;
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        side_d    = side_q;
        full_d    = full_q;
        h_d       = h_q;
        top_d     = top_q;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = plot_q;
        done_d    = 1'b0;
        bad_d     = bad_q;
        div_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (slice_valid && ready_q) begin
                    col_d  = slice_x;
                    side_d = slice_side;
                    full_d = slice_dist[DIST_W-1] || (slice_dist == '0);
                    if (slice_x >= 8'(SCREEN_W)) begin
                        bad_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (slice_dist[DIST_W-1] || (slice_dist == '0)) begin
                        state_d = ST_CALC;
                    end else begin
                        div_start = 1'b1;
                        state_d   = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: begin
                if (div_done)
                    state_d = ST_CALC;
            end
            // Row 0 is registered here so plot/x/y/colour line up in DRAW.
            ST_CALC: begin
                h_d      = h_calc;
                top_d    = top_calc;
                x_d      = col_q;
                y_d      = '0;
                plot_d   = 1'b1;
                colour_d = row_colour('0, top_calc, h_calc, side_q);
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                if (y_q == 7'(SCREEN_H - 1)) begin
                    plot_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    y_d      = y_q + 7'd1;
                    colour_d = row_colour(y_q + 7'd1, top_q, h_q, side_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    assign slice_ready = ready_q;
    assign x           = x_q;
    assign y           = y_q;
    assign colour      = colour_q;
    assign plot        = plot_q;
    assign column_done = done_q;
    assign bad_slice   = bad_q;

endmodule

// File: doc/wall_slice_renderer.md
# wall_slice_renderer

Downstream consumer of the fixed-point ray-distance stage. It accepts one ray result per screen column: a column index, a signed integer perpendicular wall distance, and a wall-face flag. It computes the projected wall height with an iterative divider, then streams one full column of pixels (ceiling, wall, floor) to the VGA adapter's plot interface. It processes one slice at a time, with a valid/ready handshake on the input side.

## Interface
- SCREEN_W, 160, columns per frame; valid slice_x is 0..SCREEN_W-1
- SCREEN_H, 120, rows per column
- DIST_W, 21, width of signed distance input, matching the fixed-point stage's integer output
- WALL_K, 7680, projection constant; height = WALL_K / dist
- CEIL_COLOUR, 3'b001; FLOOR_COLOUR, 3'b010; WALL_COLOUR_A, 3'b111; WALL_COLOUR_B, 3'b110
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- slice_valid  in  1  slice presented
- slice_ready  out  1  block can accept a slice (IDLE only)
- slice_x  in  8  column index
- slice_dist  in  DIST_W  signed perpendicular distance
- slice_side  in  1  0 = face A, 1 = face B
- x  out  8  plot column
- y  out  7  plot row
- colour  out  3  plot colour
- plot  out  1  pixel write strobe, one pixel per cycle
- column_done  out  1  one-cycle pulse at end of slice
- bad_slice  out  1  sticky; set when slice_x >= SCREEN_W; cleared by reset only

## Operation
- States: IDLE, DIVIDE, CALC, DRAW, DONE.
- IDLE: slice_ready=1. When slice_valid && slice_ready, the block latches x, dist and side, then moves to:
  - DONE, if slice_x >= SCREEN_W. No plotting; bad_slice is set.
  - CALC, with height=SCREEN_H, if dist <= 0.
  - DIVIDE otherwise.
- DIVIDE: restoring unsigned divide of WALL_K by dist. One quotient bit per cycle, DIST_W cycles, producing a DIST_W-bit quotient.
- CALC:
  - h = min(quotient, SCREEN_H).
  - top = (SCREEN_H - h) >> 1, floor division.
  - Wall rows are top <= y < top+h. When h=0 there are no wall rows.
- DRAW: y steps 0..SCREEN_H-1, one per cycle, with plot=1 and x=latched slice_x. Colour per row:
  - CEIL_COLOUR when y < top.
  - Wall colour (selected by side) inside the wall band.
  - FLOOR_COLOUR below the band.
- DONE: column_done=1 for one cycle, then IDLE.
- slice_valid is ignored outside IDLE. Upstream must hold its data until the handshake completes.
- All arithmetic in DIVIDE and CALC is unsigned. dist is used only after the dist > 0 check.

## Timing
- Accept edge = cycle N. For a normal slice:
  - DIVIDE: N+1..N+21.
  - CALC: N+22.
  - DRAW: N+23..N+142, y=0..119.
  - DONE: N+143.
  - slice_ready high again at N+144.
- dist <= 0: DIVIDE is skipped. CALC is N+1, DRAW N+2..N+121, DONE N+122.
- Out-of-range x: DONE at N+1, zero plot cycles.
- All outputs are registered. plot, x, y and colour are valid in the same cycle.
- Back-to-back: the next slice can be accepted in the first IDLE cycle after DONE, which is a 1-cycle bubble.
- Reset (async, resetn=0):
  - State goes to IDLE.
  - x, y, colour, plot, column_done and bad_slice all reset to 0.
  - slice_ready=0 while resetn=0, and becomes 1 on the first clock after release.
- Reset mid-DIVIDE or mid-DRAW aborts the slice with no further plots and no column_done.

## Structure
- The shared package raycast_pkg holds:
  - SCREEN_W, SCREEN_H, DIST_W, WALL_K.
  - The colour constants.
  - The state encoding for this block.
- One sub-module: seq_udivider.
  - Ports: start, dividend, divisor, quotient, done.
  - Iterative restoring divider, DIST_W cycles.
  - Reused by later texture/shading stages.

## Test plan
- dist=128, side=0, x=5:
  - h=60, top=30.
  - 120 plots at x=5: y 0..29 are 001, y 30..89 are 111, y 90..119 are 010.
  - column_done at N+143.
- dist=32, side=1: quotient 240 clamps to h=120, top=0. All 120 rows are 110.
- dist=0, then dist=-7: no DIVIDE, full wall, column_done at N+122 in both cases.
- dist=7681: h=0, top=60. Rows 0..59 are ceiling, rows 60..119 are floor, no wall pixels.
- slice_x=200: no plot, column_done at N+1, bad_slice=1 and stays 1 across the next valid slice.
- resetn asserted at DRAW row 40:
  - Outputs are 0 immediately, no column_done.
  - After release, slice_ready=1 and a new slice with dist=128 renders correctly.
